m_7seg_scan: RTL and testbench

M_7SEG_SCAN -- requirements
Module: m_7seg_scan

---
 rtl/m_7seg_scan_pkg.sv | 37 +++
 rtl/m_7seg_scan_if.sv | 13 +
 rtl/m_tickdiv.sv | 37 +++
 rtl/m_7seg_scan.sv | 106 ++++++++++
 tb/tb_m_7seg_scan.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_7seg_scan_pkg.sv
// Shared types, defaults and digit helpers for the 4-digit multiplexed
// 7-segment scanner.
package m_7seg_scan_pkg;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_e;

  localparam int N_DIGITS      = 4;
  localparam int IDX_W         = $clog2(N_DIGITS);
  localparam int P_DIV_DEFAULT = 50000;
  localparam int P_GAP_DEFAULT = 500;

  function automatic logic [N_DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
    return N_DIGITS'(1) << idx;
  endfunction

  // A digit is blank when it and every more-significant nibble are zero;
  // digit 0 always shows so a zero value still displays "0".
  function automatic logic digit_blank(input logic [IDX_W-1:0] idx,
                                       input logic [15:0]      val,
                                       input logic             lzb);
    logic b;
    b = 1'b0;
    if (lzb) begin
      case (idx)
        2'd1:    b = (val[15:4]  == 12'h000);
        2'd2:    b = (val[15:8]  == 8'h00);
        2'd3:    b = (val[15:12] == 4'h0);
        default: b = 1'b0;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/m_7seg_scan_if.sv
// Load/blanking inputs and registered display outputs of the scanner,
// grouped as one bundle with master (driver) and slave (scanner) views.
interface m_7seg_scan_if;
  logic        w_we;
  logic [15:0] w_val;
  logic        w_lzb;
  logic [3:0]  r_nib;
  logic [3:0]  r_an;
  logic        r_frame;

  modport master (output w_we, w_val, w_lzb, input r_nib, r_an, r_frame);
  modport slave  (input w_we, w_val, w_lzb, output r_nib, r_an, r_frame);
endinterface

// File: rtl/m_tickdiv.sv
// Prescaler: counts enabled cycles 0..P_CNT-1 and flags the last one with a
// terminal-count pulse, then wraps to 0. Synchronous clear and reset.
module m_tickdiv #(
  parameter int P_CNT = 2
) (
  input  logic w_clk,
  input  logic w_rst,
  input  logic w_clr,
  input  logic w_en,
  output logic r_tc
);

  localparam int           W    = (P_CNT > 1) ? $clog2(P_CNT) : 1;
  localparam logic [W-1:0] LAST = W'(P_CNT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign r_tc = w_en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (w_clr || r_tc) begin
      cnt_d = '0;
    end else if (w_en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/m_7seg_scan.sv
// Four-digit multiplexed 7-segment scanner: SHOW/GAP time slots per digit,
// frame-synchronous commit of a shadow value, optional leading-zero blanking.
module m_7seg_scan
  import m_7seg_scan_pkg::*;
#(
  parameter int P_DIV = P_DIV_DEFAULT,
  parameter int P_GAP = P_GAP_DEFAULT
) (
  input  logic            w_clk,
  input  logic            w_rst,
  m_7seg_scan_if.slave    bus
);

  state_e             state_q, state_d;
  logic               run_q, run_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        shadow_q, shadow_d;
  logic [15:0]        disp_q, disp_d;
  logic [3:0]         nib_q, nib_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic               frame_q, frame_d;

  logic show_en, gap_en, tick_clr, show_tc, gap_tc;
  logic enter_show, commit;

  // run_q is low only in reset; the first edge after it acts as a GAP(3)->SHOW(0) commit.
  assign tick_clr = !run_q;
  assign show_en  = run_q && (state_q == SHOW);
  assign gap_en   = run_q && (state_q == GAP);

  m_tickdiv #(.P_CNT(P_DIV)) u_show_div (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_clr (tick_clr),
    .w_en  (show_en),
    .r_tc  (show_tc)
  );

  m_tickdiv #(.P_CNT(P_GAP)) u_gap_div (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_clr (tick_clr),
    .w_en  (gap_en),
    .r_tc  (gap_tc)
  );

  always_comb begin
    run_d      = 1'b1;
    state_d    = state_q;
    idx_d      = idx_q;
    disp_d     = disp_q;
    shadow_d   = bus.w_we ? bus.w_val : shadow_q;
    enter_show = 1'b0;
    commit     = 1'b0;

    if (!run_q) begin
      state_d    = SHOW;
      idx_d      = '0;
      enter_show = 1'b1;
      commit     = 1'b1;
    end else if (state_q == SHOW) begin
      if (show_tc) state_d = GAP;
    end else if (gap_tc) begin
      state_d    = SHOW;
      idx_d      = idx_q + IDX_W'(1);
      enter_show = 1'b1;
      commit     = (idx_q == IDX_W'(N_DIGITS - 1));
    end

    // A load in the commit cycle bypasses the shadow so it lands in this frame.
    if (commit) disp_d = bus.w_we ? bus.w_val : shadow_q;

    // Outputs are registered from next-state values so they line up with the state.
    nib_d   = enter_show ? disp_d[{idx_d, 2'b00} +: 4] : nib_q;
    an_d    = ((state_d == SHOW) && !digit_blank(idx_d, disp_d, bus.w_lzb))
              ? digit_onehot(idx_d) : '0;
    frame_d = commit;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      run_q    <= 1'b0;
      state_q  <= SHOW;
      idx_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      nib_q    <= '0;
      an_q     <= '0;
      frame_q  <= 1'b0;
    end else begin
      run_q    <= run_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      nib_q    <= nib_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.r_nib   = nib_q;
  assign bus.r_an    = an_q;
  assign bus.r_frame = frame_q;

endmodule

// File: tb/tb_m_7seg_scan.sv
// Bench for m_7seg_scan with P_DIV=4, P_GAP=1: a frame-position reference
// model predicts r_an/r_nib/r_frame every cycle under directed and random stimulus.
module tb_m_7seg_scan;

  localparam int PD    = 4;
  localparam int PG    = 1;
  localparam int SLOT  = PD + PG;
  localparam int FRAME = 4 * SLOT;

  logic w_clk = 1'b0;
  logic w_rst = 1'b1;

  m_7seg_scan_if bus ();

  m_7seg_scan #(.P_DIV(PD), .P_GAP(PG)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  always #5 w_clk = ~w_clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: position inside the frame since the last reset release.
  bit          running = 1'b0;
  int          t       = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_disp   = '0;
  logic [3:0]  exp_an   = '0;
  logic [3:0]  exp_nib  = '0;
  logic        exp_frame = 1'b0;

  task automatic tick(input logic rst, input logic we, input logic [15:0] val, input logic lzb);
    int pos, dig;
    w_rst     = rst;
    bus.w_we  = we;
    bus.w_val = val;
    bus.w_lzb = lzb;
    @(posedge w_clk);
    cyc++;
    if (rst) begin
      running = 1'b0; t = 0; m_shadow = '0; m_disp = '0;
      exp_an = '0; exp_nib = '0; exp_frame = 1'b0;
    end else begin
      if (!running) begin running = 1'b1; t = 0; end
      else t++;
      pos = t % FRAME;
      if (pos == 0) m_disp = we ? val : m_shadow;
      if (we) m_shadow = val;
      dig       = pos / SLOT;
      exp_nib   = 4'((m_disp >> (4 * dig)) & 16'hF);
      exp_frame = (pos == 0);
      if (((pos % SLOT) < PD) && !(lzb && dig != 0 && (m_disp >> (4 * dig)) == 16'h0))
        exp_an = 4'(1 << dig);
      else
        exp_an = 4'b0000;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 16'hFFFF, 1'b0);
      n_chk++;
      if ({bus.r_an, bus.r_nib, bus.r_frame} !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_hold an=%b nib=%h fr=%b want an=0000 nib=0 fr=0", bus.r_an, bus.r_nib, bus.r_frame);
      end
    end
    tick(1'b0, 1'b0, 16'h0000, 1'b0);
    n_chk++;
    if ({bus.r_an, bus.r_nib, bus.r_frame} !== {4'b0001, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_release an=%b nib=%h fr=%b want an=0001 nib=0 fr=1", bus.r_an, bus.r_nib, bus.r_frame);
    end
  endtask

  task automatic test_load_1234();
    logic [3:0] want[4];
    want = '{4'h4, 4'h3, 4'h2, 4'h1};
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    tick(1'b0, 1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 2 * FRAME - 2; i++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b0);
      n_chk++;
      if ({bus.r_an, bus.r_nib, bus.r_frame} !== {exp_an, exp_nib, exp_frame}) begin
        n_fail++;
        $display("FAIL load_1234 t=%0d an=%b nib=%h fr=%b want an=%b nib=%h fr=%b",
                 t, bus.r_an, bus.r_nib, bus.r_frame, exp_an, exp_nib, exp_frame);
      end
      if (t >= FRAME && (t % SLOT) == 0) begin
        n_chk++;
        if (bus.r_nib !== want[(t - FRAME) / SLOT] || bus.r_an !== 4'(1 << ((t - FRAME) / SLOT))) begin
          n_fail++;
          $display("FAIL load_1234_digit t=%0d nib=%h an=%b want nib=%h", t, bus.r_nib, bus.r_an,
                   want[(t - FRAME) / SLOT]);
        end
      end
    end
  endtask

  task automatic test_lzb(input logic [15:0] val, input logic lzb, input logic [3:0] want_mask);
    logic [3:0] seen;
    seen = '0;
    tick(1'b1, 1'b0, 16'h0, lzb);
    tick(1'b0, 1'b0, 16'h0, lzb);
    tick(1'b0, 1'b1, val, lzb);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1'b0, 1'b0, 16'h0, lzb);
      n_chk++;
      if ({bus.r_an, bus.r_nib, bus.r_frame} !== {exp_an, exp_nib, exp_frame}) begin
        n_fail++;
        $display("FAIL lzb_%h_%0b t=%0d an=%b nib=%h fr=%b want an=%b nib=%h fr=%b", val, lzb,
                 t, bus.r_an, bus.r_nib, bus.r_frame, exp_an, exp_nib, exp_frame);
      end
      if (t >= FRAME) seen |= bus.r_an;
    end
    n_chk++;
    if (seen !== want_mask) begin
      n_fail++;
      $display("FAIL lzb_mask_%h_%0b seen=%b want=%b", val, lzb, seen, want_mask);
    end
  endtask

  task automatic test_bypass();
    logic [3:0] got[4];
    logic [3:0] want[4];
    want = '{4'hF, 4'hE, 4'hE, 4'hB};
    got  = '{4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < FRAME && ((t + 1) % FRAME) != 0; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
    n_chk++;
    if (((t + 1) % FRAME) != 0) begin
      n_fail++;
      $display("FAIL bypass_align t=%0d not at commit cycle", t);
    end
    tick(1'b0, 1'b1, 16'hBEEF, 1'b0);
    n_chk++;
    if (bus.r_frame !== 1'b1 || bus.r_nib !== 4'hF) begin
      n_fail++;
      $display("FAIL bypass_commit fr=%b nib=%h want fr=1 nib=f", bus.r_frame, bus.r_nib);
    end
    got[0] = bus.r_nib;
    for (int i = 1; i < FRAME; i++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b0);
      n_chk++;
      if ({bus.r_an, bus.r_nib, bus.r_frame} !== {exp_an, exp_nib, exp_frame}) begin
        n_fail++;
        $display("FAIL bypass t=%0d an=%b nib=%h fr=%b want an=%b nib=%h fr=%b",
                 t, bus.r_an, bus.r_nib, bus.r_frame, exp_an, exp_nib, exp_frame);
      end
      if ((i % SLOT) == 0) got[i / SLOT] = bus.r_nib;
    end
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL bypass_digits got=%h%h%h%h want=fee b", got[0], got[1], got[2], got[3]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < FRAME && (t % FRAME) != 2 * SLOT + 1; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
    n_chk++;
    if ((t % FRAME) != 2 * SLOT + 1 || bus.r_an !== 4'b0100) begin
      n_fail++;
      $display("FAIL rstmid_align t=%0d an=%b want an=0100", t, bus.r_an);
    end
    tick(1'b1, 1'b1, 16'h9999, 1'b0);
    n_chk++;
    if (bus.r_an !== 4'b0000 || bus.r_nib !== 4'h0 || bus.r_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_hold an=%b nib=%h fr=%b want an=0000 nib=0 fr=0", bus.r_an, bus.r_nib, bus.r_frame);
    end
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    n_chk++;
    if (bus.r_an !== 4'b0001 || bus.r_nib !== 4'h0 || bus.r_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_release an=%b nib=%h fr=%b want an=0001 nib=0 fr=1", bus.r_an, bus.r_nib, bus.r_frame);
    end
    for (int i = 1; i < FRAME; i++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b0);
      n_chk++;
      if ({bus.r_an, bus.r_nib, bus.r_frame} !== {exp_an, exp_nib, exp_frame} || bus.r_nib !== 4'h0) begin
        n_fail++;
        $display("FAIL rstmid t=%0d an=%b nib=%h fr=%b want an=%b nib=0 fr=%b",
                 t, bus.r_an, bus.r_nib, bus.r_frame, exp_an, exp_frame);
      end
    end
  endtask

  task automatic test_back_to_back();
    int last_fr;
    last_fr = -1;
    for (int i = 0; i < FRAME && (t % FRAME) != 0; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == 3)      tick(1'b0, 1'b1, 16'h1111, 1'b0);
      else if (i == 8) tick(1'b0, 1'b1, 16'h2222, 1'b0);
      else             tick(1'b0, 1'b0, 16'h0, 1'b0);
      n_chk++;
      if ({bus.r_an, bus.r_nib, bus.r_frame} !== {exp_an, exp_nib, exp_frame}) begin
        n_fail++;
        $display("FAIL b2b t=%0d an=%b nib=%h fr=%b want an=%b nib=%h fr=%b",
                 t, bus.r_an, bus.r_nib, bus.r_frame, exp_an, exp_nib, exp_frame);
      end
      if (i >= FRAME - 1 && (t % SLOT) == 0) begin
        n_chk++;
        if (bus.r_nib !== 4'h2) begin
          n_fail++;
          $display("FAIL b2b_digit t=%0d nib=%h want 2", t, bus.r_nib);
        end
      end
      if (bus.r_frame === 1'b1) begin
        if (last_fr >= 0) begin
          n_chk++;
          if (cyc - last_fr != FRAME) begin
            n_fail++;
            $display("FAIL b2b_period got=%0d want=%0d", cyc - last_fr, FRAME);
          end
        end
        last_fr = cyc;
      end
    end
  endtask

  task automatic test_random();
    logic        lzb_r, we, rst;
    logic [15:0] val;
    logic [15:0] masks[5];
    int          last_fr;
    masks   = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000, 16'h0F0F};
    lzb_r   = 1'b1;
    last_fr = -1;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 49) == 0) lzb_r = ~lzb_r;
      rst = ($urandom_range(0, 399) == 0);
      we  = ($urandom_range(0, 7) == 0);
      val = 16'($urandom) & masks[$urandom_range(0, 4)];
      tick(rst, we, val, lzb_r);
      n_chk++;
      if ({bus.r_an, bus.r_nib, bus.r_frame} !== {exp_an, exp_nib, exp_frame}) begin
        n_fail++;
        $display("FAIL random cyc=%0d t=%0d an=%b nib=%h fr=%b want an=%b nib=%h fr=%b",
                 cyc, t, bus.r_an, bus.r_nib, bus.r_frame, exp_an, exp_nib, exp_frame);
      end
      if (rst) begin
        last_fr = -1;
      end else if (bus.r_frame === 1'b1) begin
        if (last_fr >= 0) begin
          n_chk++;
          if (cyc - last_fr != FRAME) begin
            n_fail++;
            $display("FAIL random_period got=%0d want=%0d", cyc - last_fr, FRAME);
          end
        end
        last_fr = cyc;
      end
    end
  endtask

  initial begin
    bus.w_we  = 1'b0;
    bus.w_val = '0;
    bus.w_lzb = 1'b0;
    test_reset();
    test_load_1234();
    test_lzb(16'h0050, 1'b1, 4'b0011);
    test_lzb(16'h0000, 1'b1, 4'b0001);
    test_lzb(16'h0000, 1'b0, 4'b1111);
    test_bypass();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

endmodule
